// File: rtl/pak_dsp_cmd_pkg.sv
// Shared definitions for the pak_dsp command bridge: FSM states and header field positions.
package pak_dsp_cmd_pkg;

    typedef enum logic [2:0] {
        S_HDR     = 3'd0,
        S_WR      = 3'd1,
        S_RD_ADDR = 3'd2,
        S_RD_WAIT = 3'd3,
        S_RD_RESP = 3'd4
    } state_t;

    localparam int OP_BIT  = 15;
    localparam int RSV_BIT = 14;
    localparam int LEN_MSB = 13;
    localparam int LEN_LSB = 8;

endpackage

// File: rtl/pak_dsp_cmd_bridge.sv
// Command-stream to register-bus initiator: parses header/payload words, drives
// single-cycle writes and returns read data through a one-entry response stage.
module pak_dsp_cmd_bridge
    import pak_dsp_cmd_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6,
    parameter int ADDR_MAX   = 62,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] cmd_data_in,
    input  logic                  cmd_valid_in,
    output logic                  cmd_ready_out,
    output logic [DATA_WIDTH-1:0] rsp_data_out,
    output logic                  rsp_valid_out,
    input  logic                  rsp_ready_in,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  write_en,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  err_sticky
);

    localparam logic [ADDR_WIDTH-1:0] AMAX = ADDR_WIDTH'(ADDR_MAX);

    // Both streams: a word moves on a rising edge where valid && ready; the
    // producer holds data stable while valid && !ready.
    state_t                  state;
    logic [5:0]              count;     // words remaining after the current one
    logic [ADDR_WIDTH-1:0]   wr_ptr;    // address of the next payload word to write
    logic                    cmd_fire;
    logic                    hdr_bad;
    logic [ADDR_WIDTH-1:0]   hdr_start;
    logic [5:0]              hdr_len;
    logic                    hdr_unused;

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        return (a == AMAX) ? '0 : a + ADDR_WIDTH'(1);
    endfunction

    assign hdr_start  = cmd_data_in[ADDR_WIDTH-1:0];
    assign hdr_len    = cmd_data_in[LEN_MSB:LEN_LSB];
    assign hdr_bad    = cmd_data_in[RSV_BIT] || (hdr_start > AMAX);
    assign hdr_unused = ^cmd_data_in;

    assign cmd_ready_out = !rst && ((state == S_HDR) || (state == S_WR));
    assign cmd_fire      = cmd_valid_in && cmd_ready_out;
    assign busy          = (state != S_HDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_HDR;
            count         <= '0;
            wr_ptr        <= '0;
            addr          <= '0;
            write_en      <= 1'b0;
            wdata         <= '0;
            rsp_data_out  <= '0;
            rsp_valid_out <= 1'b0;
            err_sticky    <= 1'b0;
        end else begin
            write_en <= 1'b0;
            case (state)
                S_HDR: begin
                    if (cmd_fire) begin
                        if (hdr_bad) begin
                            err_sticky <= 1'b1;
                        end else begin
                            count  <= hdr_len;
                            wr_ptr <= hdr_start;
                            addr   <= hdr_start;
                            state  <= cmd_data_in[OP_BIT] ? S_WR : S_RD_ADDR;
                        end
                    end
                end
                S_WR: begin
                    // The strobe lands the cycle after acceptance, so addr is
                    // loaded from wr_ptr together with wdata.
                    if (cmd_fire) begin
                        addr     <= wr_ptr;
                        wdata    <= cmd_data_in;
                        write_en <= 1'b1;
                        wr_ptr   <= next_addr(wr_ptr);
                        if (count == 6'd0) begin
                            state <= S_HDR;
                        end else begin
                            count <= count - 6'd1;
                        end
                    end
                end
                S_RD_ADDR: begin
                    if (RD_LAT == 0) begin
                        rsp_data_out  <= rdata;
                        rsp_valid_out <= 1'b1;
                        state         <= S_RD_RESP;
                    end else begin
                        state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    rsp_data_out  <= rdata;
                    rsp_valid_out <= 1'b1;
                    state         <= S_RD_RESP;
                end
                S_RD_RESP: begin
                    if (rsp_ready_in) begin
                        rsp_valid_out <= 1'b0;
                        addr          <= next_addr(addr);
                        if (count == 6'd0) begin
                            state <= S_HDR;
                        end else begin
                            count <= count - 6'd1;
                            state <= S_RD_ADDR;
                        end
                    end
                end
                default: state <= S_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_pak_dsp_cmd_bridge.sv
// Directed bench for pak_dsp_cmd_bridge: writes, wrapping bursts, reads with
// backpressure, malformed headers and reset mid-burst.
module tb_pak_dsp_cmd_bridge;
    import pak_dsp_cmd_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] cmd_data_in;
    logic        cmd_valid_in;
    logic        cmd_ready_out;
    logic [15:0] rsp_data_out;
    logic        rsp_valid_out;
    logic        rsp_ready_in;
    logic [5:0]  addr;
    logic        write_en;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        busy;
    logic        err_sticky;

    int checks;
    int failures;
    int we_count;
    int we_in_read;

    pak_dsp_cmd_bridge #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(6),
        .ADDR_MAX  (62),
        .RD_LAT    (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_data_in  (cmd_data_in),
        .cmd_valid_in (cmd_valid_in),
        .cmd_ready_out(cmd_ready_out),
        .rsp_data_out (rsp_data_out),
        .rsp_valid_out(rsp_valid_out),
        .rsp_ready_in (rsp_ready_in),
        .addr         (addr),
        .write_en     (write_en),
        .wdata        (wdata),
        .rdata        (rdata),
        .busy         (busy),
        .err_sticky   (err_sticky)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model with one cycle of read latency: returns addr + 0x100
    always @(posedge clk) rdata <= 16'h0100 + 16'(addr);

    // Write-strobe monitor
    always @(negedge clk) begin
        if (write_en) begin
            we_count++;
            if ((dut.state == S_RD_ADDR) || (dut.state == S_RD_WAIT) || (dut.state == S_RD_RESP))
                we_in_read++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one command word and return #1 after the edge that accepted it
    task automatic send_word(input logic [15:0] w);
        int n;
        cmd_data_in  = w;
        cmd_valid_in = 1'b1;
        n = 0;
        while (!cmd_ready_out && n < 20) begin
            step();
            n++;
        end
        check("send_ready", 32'(cmd_ready_out), 32'd1);
        step();
        cmd_valid_in = 1'b0;
    endtask

    initial begin
        int we_before;
        checks       = 0;
        failures     = 0;
        we_count     = 0;
        we_in_read   = 0;
        rst          = 1'b1;
        cmd_data_in  = '0;
        cmd_valid_in = 1'b0;
        rsp_ready_in = 1'b1;

        // Reset state
        step(); step(); step();
        check("rst_ready", 32'(cmd_ready_out), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid_out), 32'd0);
        check("rst_rsp_data", 32'(rsp_data_out), 32'h0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_we", 32'(write_en), 32'd0);
        check("rst_wdata", 32'(wdata), 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err_sticky), 32'd0);
        rst = 1'b0;
        #1;
        check("idle_ready", 32'(cmd_ready_out), 32'd1);

        // Single write
        send_word(16'h8005);
        check("w1_busy", 32'(busy), 32'd1);
        check("w1_ready_wr", 32'(cmd_ready_out), 32'd1);
        check("w1_state", 32'(dut.state), 32'(S_WR));
        send_word(16'h1234);
        check("w1_we", 32'(write_en), 32'd1);
        check("w1_addr", 32'(addr), 32'd5);
        check("w1_wdata", 32'(wdata), 32'h1234);
        check("w1_busy_fall", 32'(busy), 32'd0);
        check("w1_ready_end", 32'(cmd_ready_out), 32'd1);
        step();
        check("w1_we_once", 32'(write_en), 32'd0);

        // Write burst with address wrap 61, 62, 0
        send_word(16'h823D);
        send_word(16'h000A);
        check("wb0_we", 32'(write_en), 32'd1);
        check("wb0_addr", 32'(addr), 32'd61);
        check("wb0_wdata", 32'(wdata), 32'h000A);
        send_word(16'h000B);
        check("wb1_we", 32'(write_en), 32'd1);
        check("wb1_addr", 32'(addr), 32'd62);
        check("wb1_wdata", 32'(wdata), 32'h000B);
        send_word(16'h000C);
        check("wb2_we", 32'(write_en), 32'd1);
        check("wb2_addr", 32'(addr), 32'd0);
        check("wb2_wdata", 32'(wdata), 32'h000C);
        check("wb_busy_end", 32'(busy), 32'd0);
        step();

        // Read burst: addr 3 then 4
        send_word(16'h0103);
        check("rd_addr0", 32'(addr), 32'd3);
        check("rd_ready0", 32'(cmd_ready_out), 32'd0);
        step();
        check("rd_wait_valid", 32'(rsp_valid_out), 32'd0);
        step();
        check("rd0_valid", 32'(rsp_valid_out), 32'd1);
        check("rd0_data", 32'(rsp_data_out), 32'h0103);
        step();
        check("rd1_addr", 32'(addr), 32'd4);
        check("rd1_valid_clr", 32'(rsp_valid_out), 32'd0);
        step();
        step();
        check("rd1_valid", 32'(rsp_valid_out), 32'd1);
        check("rd1_data", 32'(rsp_data_out), 32'h0104);
        step();
        check("rd_done_busy", 32'(busy), 32'd0);
        check("rd_done_valid", 32'(rsp_valid_out), 32'd0);

        // Same read under 5 cycles of backpressure
        rsp_ready_in = 1'b0;
        send_word(16'h0103);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", 32'(rsp_valid_out), 32'd1);
            check("bp_data", 32'(rsp_data_out), 32'h0103);
            check("bp_addr", 32'(addr), 32'd3);
            check("bp_ready", 32'(cmd_ready_out), 32'd0);
        end
        rsp_ready_in = 1'b1;
        step();
        check("bp_rel_valid", 32'(rsp_valid_out), 32'd0);
        check("bp_rel_addr", 32'(addr), 32'd4);
        step();
        step();
        check("bp1_valid", 32'(rsp_valid_out), 32'd1);
        check("bp1_data", 32'(rsp_data_out), 32'h0104);
        step();
        step();
        check("bp_no_extra", 32'(rsp_valid_out), 32'd0);
        check("bp_done_busy", 32'(busy), 32'd0);

        // Malformed headers
        we_before = we_count;
        send_word(16'h4000);
        check("bad_rsv_err", 32'(err_sticky), 32'd1);
        check("bad_rsv_busy", 32'(busy), 32'd0);
        send_word(16'h003F);
        check("bad_addr_err", 32'(err_sticky), 32'd1);
        check("bad_addr_busy", 32'(busy), 32'd0);
        step();
        check("bad_no_write", 32'(we_count), 32'(we_before));
        send_word(16'h8001);
        send_word(16'h5555);
        check("post_bad_we", 32'(write_en), 32'd1);
        check("post_bad_addr", 32'(addr), 32'd1);
        check("post_bad_wdata", 32'(wdata), 32'h5555);
        check("err_held", 32'(err_sticky), 32'd1);
        step();

        // Reset after the first of four burst words
        send_word(16'h8310);
        send_word(16'h1111);
        check("rb_we", 32'(write_en), 32'd1);
        check("rb_addr", 32'(addr), 32'h10);
        cmd_data_in  = 16'h2222;
        cmd_valid_in = 1'b1;
        rst          = 1'b1;
        step();
        check("rb_we_clr", 32'(write_en), 32'd0);
        check("rb_addr_clr", 32'(addr), 32'd0);
        check("rb_wdata_clr", 32'(wdata), 32'h0);
        check("rb_state", 32'(dut.state), 32'(S_HDR));
        check("rb_busy", 32'(busy), 32'd0);
        check("rb_err", 32'(err_sticky), 32'd0);
        check("rb_ready", 32'(cmd_ready_out), 32'd0);
        check("rb_rsp_valid", 32'(rsp_valid_out), 32'd0);
        check("rb_rsp_data", 32'(rsp_data_out), 32'h0);
        cmd_valid_in = 1'b0;
        rst          = 1'b0;
        step();
        check("rb_ready_after", 32'(cmd_ready_out), 32'd1);

        check("we_in_read", 32'(we_in_read), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
